// File: rtl/nfc_page_copy_if.sv
// rtl/nfc_page_copy_if.sv - job request/status handshake between a host and nfc_page_copy
interface nfc_page_copy_if #(
    parameter int ROW_W = 9
) ();
    logic             start;
    logic [ROW_W-1:0] src_page;
    logic [ROW_W-1:0] dst_page;
    logic [ROW_W:0]   page_count;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start, src_page, dst_page, page_count,
        input  busy, done, error
    );

    modport slave (
        input  start, src_page, dst_page, page_count,
        output busy, done, error
    );
endinterface

// File: rtl/nfc_page_copy.sv
// rtl/nfc_page_copy.sv - copies a run of NAND pages from flash A to flash B
// Page data streams A->B two clocks per byte; B is programmed and status-checked per page.
module nfc_page_copy #(
    parameter int PAGE_BYTES = 512,
    parameter int ROW_W      = 9,
    parameter int RB_TIMEOUT = 65535
) (
    input  logic           clk,
    input  logic           rst,
    nfc_page_copy_if.slave job,
    inout  wire  [7:0]     f_io_a_io,
    output logic           f_cle_a_o,
    output logic           f_ale_a_o,
    output logic           f_ren_a_o,
    output logic           f_wen_a_o,
    input  logic           f_rb_a_i,
    inout  wire  [7:0]     f_io_b_io,
    output logic           f_cle_b_o,
    output logic           f_ale_b_o,
    output logic           f_ren_b_o,
    output logic           f_wen_b_o,
    input  logic           f_rb_b_i
);
    localparam int XFER_CYC = 2 * PAGE_BYTES;
    localparam int CNT_MAX  = (RB_TIMEOUT > XFER_CYC) ? RB_TIMEOUT : XFER_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_CYC);
    localparam logic [CNT_W-1:0] XFER_PEN  = CNT_W'(XFER_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(RB_TIMEOUT - 1);
    localparam logic [ROW_W:0]   ONE_PAGE  = (ROW_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD_ADDR, S_WAIT_A, S_XFER, S_PROG, S_WAIT_B, S_STATUS, S_NEXT
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ROW_W-1:0] src_q;
    logic [ROW_W-1:0] dst_q;
    logic [ROW_W:0]   pages_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             cle_a_q, ale_a_q, wen_a_q, ren_a_q, oe_a_q;
    logic             cle_b_q, ale_b_q, wen_b_q, ren_b_q, oe_b_q;
    logic [7:0]       io_a_q;
    logic [7:0]       io_b_q;
    logic [2:0]       rb_a_q;
    logic [2:0]       rb_b_q;

    logic [2:0]       ca_step_d;
    logic [7:0]       byte_a_d;
    logic [7:0]       byte_b_d;
    logic [15:0]      src_row16;
    logic [15:0]      dst_row16;
    logic             ca_go_d;
    logic             accept_d;
    logic             rb_a_rise;
    logic             rb_b_rise;

    // Bits [1] are the synchronized R/B levels, bits [2] their previous value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_a_q <= '0;
            rb_b_q <= '0;
        end else begin
            rb_a_q <= {rb_a_q[1:0], f_rb_a_i};
            rb_b_q <= {rb_b_q[1:0], f_rb_b_i};
        end
    end

    assign rb_a_rise = rb_a_q[1] & ~rb_a_q[2];
    assign rb_b_rise = rb_b_q[1] & ~rb_b_q[2];

    // ca_step_d is the command/address bus step that the coming cycle will present.
    always_comb begin
        src_row16 = 16'(src_q);
        dst_row16 = 16'(dst_q);
        accept_d  = (state_q == S_IDLE) && job.start && !busy_q;
        ca_step_d = (state_q == S_CMD_ADDR) ? cnt_q[2:0] + 3'd1 : 3'd0;
        ca_go_d   = (accept_d && (job.page_count != '0))
                 || ((state_q == S_CMD_ADDR) && (cnt_q[2:0] != 3'd7))
                 || ((state_q == S_NEXT) && (pages_q != ONE_PAGE));
        case (ca_step_d[2:1])
            2'd0: begin
                byte_a_d = 8'h00;
                byte_b_d = 8'h80;
            end
            2'd1: begin
                byte_a_d = 8'h00;
                byte_b_d = 8'h00;
            end
            2'd2: begin
                byte_a_d = src_row16[7:0];
                byte_b_d = dst_row16[7:0];
            end
            default: begin
                byte_a_d = src_row16[15:8];
                byte_b_d = dst_row16[15:8];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            pages_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cle_a_q <= 1'b0;
            ale_a_q <= 1'b0;
            wen_a_q <= 1'b1;
            ren_a_q <= 1'b1;
            oe_a_q  <= 1'b0;
            io_a_q  <= 8'h00;
            cle_b_q <= 1'b0;
            ale_b_q <= 1'b0;
            wen_b_q <= 1'b1;
            ren_b_q <= 1'b1;
            oe_b_q  <= 1'b0;
            io_b_q  <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (accept_d) begin
                        src_q   <= job.src_page;
                        dst_q   <= job.dst_page;
                        pages_q <= job.page_count;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        if (job.page_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_CMD_ADDR;
                        end
                    end
                end
                S_CMD_ADDR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q[2:0] == 3'd7) begin
                        state_q <= S_WAIT_A;
                        cnt_q   <= '0;
                        cle_a_q <= 1'b0;
                        ale_a_q <= 1'b0;
                        wen_a_q <= 1'b1;
                        oe_a_q  <= 1'b0;
                        cle_b_q <= 1'b0;
                        ale_b_q <= 1'b0;
                        wen_b_q <= 1'b1;
                        oe_b_q  <= 1'b0;
                    end
                end
                S_WAIT_A: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (rb_a_rise) begin
                        state_q <= S_XFER;
                        cnt_q   <= '0;
                        ren_a_q <= 1'b0;
                    end else if (cnt_q == TMO_LAST) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_XFER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == XFER_LAST) begin
                        state_q <= S_PROG;
                        cnt_q   <= '0;
                        cle_b_q <= 1'b1;
                        wen_b_q <= 1'b0;
                        io_b_q  <= 8'h10;
                        oe_b_q  <= 1'b1;
                    end else if (!cnt_q[0]) begin
                        // End of the A read strobe: the byte goes straight onto B's bus.
                        ren_a_q <= 1'b1;
                        wen_b_q <= 1'b0;
                        io_b_q  <= f_io_a_io;
                        oe_b_q  <= 1'b1;
                    end else begin
                        wen_b_q <= 1'b1;
                        ren_a_q <= (cnt_q == XFER_PEN);
                    end
                end
                S_PROG: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!cnt_q[0]) begin
                        wen_b_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT_B;
                        cnt_q   <= '0;
                        cle_b_q <= 1'b0;
                        oe_b_q  <= 1'b0;
                    end
                end
                S_WAIT_B: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (rb_b_rise) begin
                        state_q <= S_STATUS;
                        cnt_q   <= '0;
                        cle_b_q <= 1'b1;
                        wen_b_q <= 1'b0;
                        io_b_q  <= 8'h70;
                        oe_b_q  <= 1'b1;
                    end else if (cnt_q == TMO_LAST) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_STATUS: begin
                    cnt_q <= cnt_q + 1'b1;
                    case (cnt_q[1:0])
                        2'd0: wen_b_q <= 1'b1;
                        2'd1: begin
                            cle_b_q <= 1'b0;
                            oe_b_q  <= 1'b0;
                            ren_b_q <= 1'b0;
                        end
                        default: begin
                            ren_b_q <= 1'b1;
                            cnt_q   <= '0;
                            if (f_io_b_io[0]) begin
                                error_q <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_NEXT;
                            end
                        end
                    endcase
                end
                S_NEXT: begin
                    pages_q <= pages_q - 1'b1;
                    src_q   <= src_q + 1'b1;
                    dst_q   <= dst_q + 1'b1;
                    cnt_q   <= '0;
                    if (pages_q == ONE_PAGE) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_CMD_ADDR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Both ports share one command/address sequencer; later assignments win over the case above.
            if (ca_go_d) begin
                cle_a_q <= (ca_step_d[2:1] == 2'd0);
                ale_a_q <= (ca_step_d[2:1] != 2'd0);
                wen_a_q <= ca_step_d[0];
                io_a_q  <= byte_a_d;
                oe_a_q  <= 1'b1;
                cle_b_q <= (ca_step_d[2:1] == 2'd0);
                ale_b_q <= (ca_step_d[2:1] != 2'd0);
                wen_b_q <= ca_step_d[0];
                io_b_q  <= byte_b_d;
                oe_b_q  <= 1'b1;
            end
        end
    end

    assign job.busy  = busy_q;
    assign job.done  = done_q;
    assign job.error = error_q;

    assign f_io_a_io = oe_a_q ? io_a_q : 8'hzz;
    assign f_cle_a_o = cle_a_q;
    assign f_ale_a_o = ale_a_q;
    assign f_ren_a_o = ren_a_q;
    assign f_wen_a_o = wen_a_q;
    assign f_io_b_io = oe_b_q ? io_b_q : 8'hzz;
    assign f_cle_b_o = cle_b_q;
    assign f_ale_b_o = ale_b_q;
    assign f_ren_b_o = ren_b_q;
    assign f_wen_b_o = wen_b_q;
endmodule

// File: tb/tb_nfc_page_copy.sv
// tb/tb_nfc_page_copy.sv - table-driven and randomized checks of nfc_page_copy against flash models
module tb_nfc_page_copy;
    localparam int PB  = 16;
    localparam int RW  = 9;
    localparam int TMO = 100;
    localparam int RDY = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nfc_page_copy_if #(.ROW_W(RW)) job ();

    wire  [7:0] f_io_a;
    wire  [7:0] f_io_b;
    logic cle_a, ale_a, ren_a, wen_a, rb_a;
    logic cle_b, ale_b, ren_b, wen_b, rb_b;

    nfc_page_copy #(.PAGE_BYTES(PB), .ROW_W(RW), .RB_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .job(job),
        .f_io_a_io(f_io_a), .f_cle_a_o(cle_a), .f_ale_a_o(ale_a),
        .f_ren_a_o(ren_a), .f_wen_a_o(wen_a), .f_rb_a_i(rb_a),
        .f_io_b_io(f_io_b), .f_cle_b_o(cle_b), .f_ale_b_o(ale_b),
        .f_ren_b_o(ren_b), .f_wen_b_o(wen_b), .f_rb_b_i(rb_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] seed = 8'h5A;
    int  fail_page = 0;
    bit  hold_a = 1'b0;
    bit  clr = 1'b0;
    logic [9:0] a_log[$];
    logic [9:0] b_log[$];
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    int  a_k = 0;
    logic [15:0] a_row = 16'h0;
    int  a_ptr = 0;
    int  a_tmr = 0;
    int  b_tmr = 0;
    int  b_prog_n = 0;
    int  act = 0;
    logic wen_a_p = 1'b1, ren_a_p = 1'b1, wen_b_p = 1'b1;

    function automatic logic [7:0] data_of(input int row, input int j, input logic [7:0] s);
        return 8'((row * 37) ^ (j * 11)) ^ s;
    endfunction

    assign f_io_a = (ren_a == 1'b0) ? data_of(int'(a_row), a_ptr, seed) : 8'hzz;
    assign f_io_b = (ren_b == 1'b0) ? ((fail_page != 0 && b_prog_n == fail_page) ? 8'h01 : 8'h00) : 8'hzz;
    assign rb_a = !hold_a && (a_tmr == 0);
    assign rb_b = (b_tmr == 0);

    // Flash models: latch bytes on WEN rising, busy for RDY cycles after read address / program confirm.
    always @(negedge clk) begin
        wen_a_p <= wen_a;
        ren_a_p <= ren_a;
        wen_b_p <= wen_b;
        if (cle_a || ale_a || !wen_a || cle_b || ale_b || !wen_b) act <= act + 1;
        if (clr) begin
            a_log.delete();
            b_log.delete();
        end
        if (wen_a && !wen_a_p) begin
            a_log.push_back({cle_a, ale_a, f_io_a});
            if (cle_a) begin
                a_k   <= 1;
                a_ptr <= 0;
            end else if (ale_a) begin
                if (a_k == 2) a_row[7:0] <= f_io_a;
                if (a_k == 3) begin
                    a_row[15:8] <= f_io_a;
                    a_tmr <= RDY;
                end
                a_k <= a_k + 1;
            end
        end else if (a_tmr > 0) begin
            a_tmr <= a_tmr - 1;
        end
        if (ren_a && !ren_a_p) a_ptr <= a_ptr + 1;
        if (wen_b && !wen_b_p) begin
            b_log.push_back({cle_b, ale_b, f_io_b});
            if (cle_b && f_io_b == 8'h10) begin
                b_tmr    <= RDY;
                b_prog_n <= b_prog_n + 1;
            end
        end else begin
            if (b_tmr > 0) b_tmr <= b_tmr - 1;
            if (clr) b_prog_n <= 0;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic build_exp(input int src, input int dst, input int n, input int fail, input bit hold);
        int sr;
        int dr;
        exp_a.delete();
        exp_b.delete();
        for (int p = 0; p < n; p++) begin
            sr = (src + p) % (1 << RW);
            dr = (dst + p) % (1 << RW);
            exp_a.push_back({2'b10, 8'h00});
            exp_a.push_back({2'b01, 8'h00});
            exp_a.push_back({2'b01, 8'(sr)});
            exp_a.push_back({2'b01, 8'(sr >> 8)});
            exp_b.push_back({2'b10, 8'h80});
            exp_b.push_back({2'b01, 8'h00});
            exp_b.push_back({2'b01, 8'(dr)});
            exp_b.push_back({2'b01, 8'(dr >> 8)});
            if (hold) return;
            for (int j = 0; j < PB; j++) exp_b.push_back({2'b00, data_of(sr, j, seed)});
            exp_b.push_back({2'b10, 8'h10});
            exp_b.push_back({2'b10, 8'h70});
            if (p + 1 == fail) return;
        end
    endtask

    task automatic cmp_logs(input string tag);
        int bad_a = -1;
        int bad_b = -1;
        chk({tag, " A byte count"}, a_log.size(), exp_a.size());
        chk({tag, " B byte count"}, b_log.size(), exp_b.size());
        for (int i = 0; i < a_log.size() && i < exp_a.size(); i++)
            if (bad_a < 0 && a_log[i] != exp_a[i]) bad_a = i;
        for (int i = 0; i < b_log.size() && i < exp_b.size(); i++)
            if (bad_b < 0 && b_log[i] != exp_b[i]) bad_b = i;
        chk({tag, " A first differing byte index"}, bad_a, -1);
        chk({tag, " B first differing byte index"}, bad_b, -1);
    endtask

    task automatic run_job(input string tag, input int src, input int dst, input int n,
                           input int fail, input bit hold, input bit poke, input bit exp_err,
                           output int done_at);
        int cyc = 0;
        int dones = 0;
        int busy_bad = 0;
        done_at = -1;
        build_exp(src, dst, n, fail, hold);
        hold_a = hold;
        fail_page = fail;
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
        job.src_page   = RW'(src);
        job.dst_page   = RW'(dst);
        job.page_count = (RW+1)'(n);
        job.start      = 1'b1;
        @(negedge clk);
        job.start      = 1'b0;
        job.src_page   = RW'($urandom);
        job.dst_page   = RW'($urandom);
        job.page_count = (RW+1)'($urandom_range(1, 7));
        while (cyc < 6000 && (done_at < 0 || cyc < done_at + 6)) begin
            cyc++;
            if (job.done) begin
                dones++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at < 0 || done_at == cyc) begin
                if (!job.busy) busy_bad++;
            end else if (cyc == done_at + 1 && job.busy) begin
                busy_bad++;
            end
            job.start = poke && (cyc == 40);
            @(negedge clk);
        end
        job.start = 1'b0;
        chk({tag, " done seen"}, done_at > 0, 1);
        chk({tag, " done pulses"}, dones, 1);
        chk({tag, " busy window errors"}, busy_bad, 0);
        chk({tag, " error"}, job.error, exp_err);
        cmp_logs(tag);
        hold_a = 1'b0;
    endtask

    task automatic zero_job(input string tag);
        int act0;
        act0 = act;
        job.src_page   = RW'(5);
        job.dst_page   = RW'(6);
        job.page_count = '0;
        job.start      = 1'b1;
        @(negedge clk);
        job.start = 1'b0;
        chk({tag, " done one cycle after start"}, job.done, 1);
        chk({tag, " busy with done"}, job.busy, 1);
        chk({tag, " error cleared"}, job.error, 0);
        @(negedge clk);
        chk({tag, " done single cycle"}, job.done, 0);
        chk({tag, " busy dropped"}, job.busy, 0);
        repeat (5) @(negedge clk);
        chk({tag, " no flash activity"}, act - act0, 0);
    endtask

    function automatic logic [10:0] out_vec();
        return {job.busy, job.done, job.error, cle_a, ale_a, wen_a, ren_a, cle_b, ale_b, wen_b, ren_b};
    endfunction

    typedef struct {
        int src;
        int dst;
        int n;
        int fail;
        bit hold;
        bit poke;
        bit exp_err;
    } vec_t;

    vec_t vecs[5];
    localparam logic [10:0] RST_VEC = 11'b000_0011_0011;

    initial begin
        int d;
        int k;
        int src, dst, n, fail;
        int act0;

        vecs[0] = '{src: 3,   dst: 7,   n: 1, fail: 0, hold: 0, poke: 0, exp_err: 0};
        vecs[1] = '{src: 511, dst: 510, n: 3, fail: 0, hold: 0, poke: 0, exp_err: 0};
        vecs[2] = '{src: 20,  dst: 40,  n: 4, fail: 2, hold: 0, poke: 0, exp_err: 1};
        vecs[3] = '{src: 100, dst: 200, n: 1, fail: 0, hold: 1, poke: 0, exp_err: 1};
        vecs[4] = '{src: 50,  dst: 60,  n: 2, fail: 0, hold: 0, poke: 1, exp_err: 0};

        job.start = 1'b0;
        job.src_page = '0;
        job.dst_page = '0;
        job.page_count = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset output values", out_vec(), RST_VEC);
        rst = 1'b0;
        @(negedge clk);

        zero_job("zero count");

        for (int i = 0; i < 5; i++) begin
            run_job($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].n, vecs[i].fail,
                    vecs[i].hold, vecs[i].poke, vecs[i].exp_err, d);
            if (vecs[i].hold) chk("timeout done latency in window", (d >= 104 && d <= 114), 1);
        end

        zero_job("zero count after error");

        for (int r = 0; r < 6; r++) begin
            seed = 8'($urandom);
            src  = $urandom_range(0, 511);
            dst  = $urandom_range(0, 511);
            n    = $urandom_range(1, 3);
            fail = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            run_job($sformatf("rand%0d", r), src, dst, n, fail, 1'b0, 1'b0, fail != 0, d);
        end

        job.src_page   = RW'(5);
        job.dst_page   = RW'(9);
        job.page_count = (RW+1)'(2);
        job.start      = 1'b1;
        @(negedge clk);
        job.start = 1'b0;
        k = 0;
        while (ren_a !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("reached XFER before reset", ren_a == 1'b0, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("outputs after mid-XFER reset", out_vec(), RST_VEC);
        rst = 1'b0;
        act0 = act;
        repeat (30) @(negedge clk);
        chk("no flash activity after reset", act - act0, 0);
        run_job("post-reset job", 5, 9, 2, 0, 1'b0, 1'b0, 1'b0, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nfc_page_copy.md
NFC_PAGE_COPY -- requirements
Module: nfc_page_copy

Interface
REQ-001 Parameter PAGE_BYTES, default 512, data bytes per page (power of 2, 16..4096).
REQ-002 Parameter ROW_W, default 9, page (row) address width (1..16).
REQ-003 Parameter RB_TIMEOUT, default 65535, max cycles waiting for R/B rising edge.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; launches a copy job.
REQ-007 src_page  in  ROW_W  first source page in flash A.
REQ-008 dst_page  in  ROW_W  first destination page in flash B.
REQ-009 page_count  in  ROW_W+1  pages to copy (0..2^ROW_W).
REQ-010 busy  out  1  job in progress.
REQ-011 done  out  1  one-cycle pulse at job end.
REQ-012 error  out  1  program-fail or timeout; held until next accepted start.
REQ-013 F_IO_A / F_IO_B  inout  8  flash data buses; released (8'hzz) when not driven.
REQ-014 F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A  out  1  flash A controls; F_RB_A in 1 ready/busy.
REQ-015 F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B  out  1  flash B controls; F_RB_B in 1 ready/busy.

Function
REQ-016 Bus cycle: every command/address/data write byte = 2 clk; cycle 1 WEN=0, IO driven; cycle 2 WEN=1, IO held (flash latches on WEN rise).
REQ-017 CLE=1 only during command cycles, ALE=1 only during address cycles; never both.
REQ-018 Address sequence per page: column 8'h00, row[7:0], row[15:8] (upper bits zero-filled); always 3 bytes.
REQ-019 States: IDLE, CMD_ADDR, WAIT_A, XFER, PROG, WAIT_B, STATUS, NEXT.
REQ-020 IDLE: start accepted only here; page_count=0 -> done pulse next cycle, error=0, no flash activity.
REQ-021 CMD_ADDR: A gets 8'h00 + address(src row); B concurrently gets 8'h80 + address(dst row); 8 clk; -> WAIT_A.
REQ-022 WAIT_A: F_RB_A passed through 2-flop synchronizer; rising edge of synchronized signal -> XFER.
REQ-023 XFER: per byte, cycle 1 REN_A=0; at end of cycle 1 capture F_IO_A; cycle 2 REN_A=1 and B write cycle 1 with captured byte; pipelined, 2 clk/byte, PAGE_BYTES bytes, last B write completes before leaving.
REQ-024 PROG: B command 8'h10 -> WAIT_B (same synchronizer/edge rule on F_RB_B).
REQ-025 STATUS: B command 8'h70, then one read cycle (REN_B low 1 clk, sample at end); bit0=1 -> error=1, abort: done pulse, -> IDLE.
REQ-026 NEXT: decrement remaining count, increment src and dst rows modulo 2^ROW_W (wrap 2^ROW_W-1 -> 0); count 0 -> done, IDLE; else CMD_ADDR.
REQ-027 Timeout: WAIT_A/WAIT_B counter reaching RB_TIMEOUT -> error=1, done pulse, IDLE; counter cleared on state entry.
REQ-028 busy=1 from cycle after accepted start until cycle of done pulse inclusive; start while busy ignored.
REQ-029 F_REN_A=1 outside XFER; F_REN_B=1 except STATUS read; F_WEN_A=1 outside CMD_ADDR.
REQ-030 Inputs src_page/dst_page/page_count sampled only on accepted start.

Reset
REQ-031 On rst: state IDLE, busy=0, done=0, error=0, CLE=ALE=0, WEN=REN=1 on both ports, both IO buses released, counters and synchronizers cleared.
REQ-032 rst mid-job takes effect next posedge; no further flash cycles issued; job not resumed.

Verification
REQ-033 PAGE_BYTES=16, src=3, dst=7, count=1, models ready after 20 clk, status 8'h00 -> A sees 00,00,03,00; B sees 80,00,07,00,16 data bytes equal A, 10, 70; done pulse, error=0.
REQ-034 ROW_W=9, src=511, dst=510, count=3 -> src rows 511,0,1; dst rows 510,511,0; single done.
REQ-035 count=0 -> done exactly one cycle after start, no CLE/ALE/WEN activity.
REQ-036 Status byte 8'h01 on page 2 of 4 -> error=1, done after page 2, no page 3 commands.
REQ-037 F_RB_A held low, RB_TIMEOUT=100 -> error=1, done ~100 clk after entering WAIT_A.
REQ-038 rst asserted mid-XFER -> next cycle all outputs at REQ-031 values; new start runs a full clean job.
